// File: rtl/seg_pkg.sv
// Shared types for the seven-segment scan path (scan controller and the
// downstream hex-to-segment/anode decoder).
package seg_pkg;

    localparam int N_DIGITS = 8;

    typedef logic [3:0] digit_t;
    typedef logic [2:0] sel_t;

endpackage : seg_pkg

// File: rtl/seg_scan_ctrl_if.sv
// Digit-write bus and scan outputs of the seven-segment scan controller.
// master = the side that writes digits and watches the scan,
// slave  = the scan controller itself.
interface seg_scan_ctrl_if;
    import seg_pkg::*;

    logic                      wr_en;
    sel_t                      wr_addr;
    digit_t                    wr_data;
    logic                      load;
    logic [N_DIGITS*4-1:0]     load_value;
    logic                      blank_lz;
    digit_t                    num;
    sel_t                      sel;
    logic                      digit_en;
    logic                      scan_tick;

    modport master (
        output wr_en, wr_addr, wr_data, load, load_value, blank_lz,
        input  num, sel, digit_en, scan_tick
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, load, load_value, blank_lz,
        output num, sel, digit_en, scan_tick
    );

endinterface : seg_scan_ctrl_if

// File: rtl/refresh_prescaler.sv
// Free-running 0..DIV-1 counter; tick is high during the last count so the
// consumer advances on the edge where the counter wraps.
module refresh_prescaler #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int              W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0]    LAST = W'(DIV - 1);

    logic [W-1:0] r_pcnt;
    logic         w_last;

    assign w_last = (r_pcnt == LAST);
    assign tick   = w_last;

    // Count up and wrap to zero after the last dwell cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt <= '0;
        end else if (w_last) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + 1'b1;
        end
    end

endmodule : refresh_prescaler

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexing scan controller for an 8-digit seven-segment display.
// Holds one hex digit per position, steps the scanned position once per
// REFRESH_DIV cycles and optionally blanks leading zeros.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic            clk,
    input  logic            rst,
    seg_scan_ctrl_if.slave  bus
);

    logic                   w_tick;
    digit_t                 r_digits [N_DIGITS];
    sel_t                   r_sel;
    logic [N_DIGITS-1:0]    w_upper_zero;   // bit i: digits[i..7] all zero
    logic                   w_blank;

    refresh_prescaler #(
        .DIV (REFRESH_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    // Digit storage: a bulk load wins over a single-digit write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                r_digits[i] <= '0;
            end
        end else if (bus.load) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                r_digits[i] <= bus.load_value[i*4 +: 4];
            end
        end else if (bus.wr_en) begin
            r_digits[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Scan position advances on every prescaler tick and wraps 7 -> 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel <= '0;
        end else if (w_tick) begin
            r_sel <= r_sel + 3'd1;
        end
    end

    // Suffix-AND chain: a position is a leading zero when it and every
    // more-significant digit are zero.
    assign w_upper_zero[N_DIGITS-1] = (r_digits[N_DIGITS-1] == '0);

    generate
        for (genvar gi = 0; gi < N_DIGITS - 1; gi++) begin : g_lz_chain
            assign w_upper_zero[gi] = (r_digits[gi] == '0) && w_upper_zero[gi+1];
        end
    endgenerate

    // Position 0 is never blanked so an all-zero value still shows "0".
    assign w_blank = bus.blank_lz && (r_sel != '0) && w_upper_zero[r_sel];

    assign bus.sel       = r_sel;
    assign bus.num       = r_digits[r_sel];
    assign bus.digit_en  = ~w_blank;
    assign bus.scan_tick = w_tick;

endmodule : seg_scan_ctrl

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (REFRESH_DIV = 4). A cycle-level
// reference model tracks edges since reset and the digit contents; scan
// position and prescaler phase are derived arithmetically from the edge count.
module tb_seg_scan_ctrl;

    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst;

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(
        .REFRESH_DIV (DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    int    m_digits [8];
    longint m_cnt;          // edges since the last reset edge

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int m_sel();
        return int'((m_cnt / DIV) % 8);
    endfunction

    function automatic int m_pcnt();
        return int'(m_cnt % DIV);
    endfunction

    function automatic int m_digit_en();
        int s;
        bit all_zero;
        s = m_sel();
        all_zero = 1'b1;
        for (int i = s; i < 8; i++) begin
            if (m_digits[i] != 0) all_zero = 1'b0;
        end
        if (bus.blank_lz && s != 0 && all_zero) return 0;
        return 1;
    endfunction

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: update the model with the inputs seen at the edge, then
    // compare every output shortly after the edge.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            m_cnt = 0;
            for (int i = 0; i < 8; i++) m_digits[i] = 0;
        end else begin
            if (bus.load) begin
                for (int i = 0; i < 8; i++) m_digits[i] = int'((bus.load_value >> (4*i)) & 32'hF);
                $display("txn load value=%08h", bus.load_value);
            end else if (bus.wr_en) begin
                m_digits[bus.wr_addr] = int'(bus.wr_data);
                $display("txn write addr=%0d data=%0h", bus.wr_addr, bus.wr_data);
            end
            m_cnt++;
        end
        #1;
        check_val("sel",       int'(bus.sel),       m_sel());
        check_val("num",       int'(bus.num),       m_digits[m_sel()]);
        check_val("digit_en",  int'(bus.digit_en),  m_digit_en());
        check_val("scan_tick", int'(bus.scan_tick), (m_pcnt() == DIV - 1) ? 1 : 0);
    endtask

    task automatic clear_strobes();
        bus.load  = 1'b0;
        bus.wr_en = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] v);
        bus.load       = 1'b1;
        bus.load_value = v;
        step();
        clear_strobes();
    endtask

    // Advance until the model reaches a given scan position and phase.
    task automatic run_to(input int s, input int p);
        int budget;
        budget = 0;
        while (!(m_sel() == s && m_pcnt() == p) && budget < 64) begin
            step();
            budget++;
        end
        if (budget >= 64) check_val("run_to_timeout", budget, 0);
    endtask

    initial begin
        logic [31:0] v;

        rst            = 1'b1;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.load       = 1'b0;
        bus.load_value = '0;
        bus.blank_lz   = 1'b0;
        m_cnt          = 0;
        for (int i = 0; i < 8; i++) m_digits[i] = 0;

        // Reset for two cycles, then check the fixed reset values directly.
        step();
        step();
        check_val("rst_sel",      int'(bus.sel),       0);
        check_val("rst_num",      int'(bus.num),       0);
        check_val("rst_digit_en", int'(bus.digit_en),  1);
        check_val("rst_tick",     int'(bus.scan_tick), 0);
        rst = 1'b0;

        // First advance happens on the 4th edge after release.
        repeat (3) step();
        check_val("first_dwell_sel", int'(bus.sel), 0);
        step();
        check_val("first_adv_sel", int'(bus.sel), 1);

        // Load and a full scan plus wrap.
        run_to(7, 3);
        do_load(32'h8765_4321);
        repeat (33) step();
        check_val("wrap_num", int'(bus.num), 1);

        // Load beats a same-cycle single write.
        bus.load       = 1'b1;
        bus.load_value = 32'h0;
        bus.wr_en      = 1'b1;
        bus.wr_addr    = 3'd2;
        bus.wr_data    = 4'hF;
        step();
        clear_strobes();
        run_to(2, 1);
        check_val("prio_d2", int'(bus.num), 0);

        // Live write to the digit currently being scanned.
        do_load(32'h8765_4321);
        run_to(3, 1);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd3;
        bus.wr_data = 4'hA;
        step();
        clear_strobes();
        check_val("live_num", int'(bus.num), 10);
        check_val("live_sel", int'(bus.sel), 3);

        // Leading-zero blanking.
        bus.blank_lz = 1'b1;
        do_load(32'h0000_0050);
        repeat (32) step();
        run_to(2, 0);
        check_val("blank_d2", int'(bus.digit_en), 0);
        do_load(32'h0);
        repeat (32) step();
        run_to(0, 1);
        check_val("allzero_d0", int'(bus.digit_en), 1);
        bus.blank_lz = 1'b0;
        repeat (32) step();

        // Reset mid-scan.
        do_load(32'h1234_5678);
        run_to(5, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("midrst_sel", int'(bus.sel), 0);
        check_val("midrst_num", int'(bus.num), 0);
        repeat (3) step();
        check_val("midrst_dwell", int'(bus.sel), 0);
        step();
        check_val("midrst_adv", int'(bus.sel), 1);

        // Randomised traffic, with nibbles biased towards zero to exercise blanking.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 8; i++) begin
                v[i*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            end
            bus.load_value = v;
            bus.load       = ($urandom_range(0, 15) == 0);
            bus.wr_en      = ($urandom_range(0, 3) == 0);
            bus.wr_addr    = 3'($urandom_range(0, 7));
            bus.wr_data    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            bus.blank_lz   = ($urandom_range(0, 3) != 0);
            rst            = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 1'b0;
        clear_strobes();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_seg_scan_ctrl
